// File: rtl/jstk2_pkg.sv
// Shared definitions for the JSTK2 SPI responder and the pmod_jstk2 master:
// frame length, responder state encoding, button bit positions and the
// layout of the report snapshot shifted out on MISO.
package jstk2_pkg;

  // Bits per SPI transaction (5 bytes).
  localparam int unsigned FRAME_BITS  = 40;

  // Bit positions inside the button byte.
  localparam int unsigned BTN_JSTK    = 0;
  localparam int unsigned BTN_TRIGGER = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Report payload, MSB is shifted out first.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  buttons;
  } jstk2_frame_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input plus edge pulses.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronized level (last synchronizer stage)
//   rise_c       : combinational pulse, synchronized level went 0 -> 1
//   fall_c       : combinational pulse, synchronized level went 1 -> 0
module sync_edge_detect #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c =  sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI slave that mimics the JSTK2 joystick: on each chip-select it snapshots
// {x, y, buttons} and shifts it out MSB first on MISO (changing on SCK
// falling edges), while capturing MOSI on SCK rising edges. The first MOSI
// byte of each completed frame is reported on rx_cmd.
// Ports:
//   clk, reset_n         : system clock, async active-low reset
//   sck, cs_n, mosi      : SPI pins from the master (asynchronous to clk)
//   miso                 : SPI data to the master
//   x_in, y_in           : positions to report
//   fs_buttons_in        : button byte to report
//   rx_cmd               : first MOSI byte of the last completed frame
//   frame_done           : one-clk pulse on a full frame ending
//   frame_abort          : one-clk pulse on a frame cut short by cs_n
//   busy                 : high while a frame is in progress
module jstk2_spi_responder
  import jstk2_pkg::state_e;
  import jstk2_pkg::ST_IDLE;
  import jstk2_pkg::ST_SHIFT;
  import jstk2_pkg::ST_DONE;
  import jstk2_pkg::jstk2_frame_t;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = jstk2_pkg::FRAME_BITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [7:0]  fs_buttons_in,
  output logic [7:0]  rx_cmd,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        busy
);

  localparam int unsigned CNT_W     = $clog2(FRAME_BITS + 1);
  localparam int unsigned FLUSH_MAX = SYNC_STAGES + 1;
  localparam int unsigned FLUSH_W   = $clog2(FLUSH_MAX + 1);

  logic sck_lvl, sck_rise_c, sck_fall_c;
  logic cs_lvl, cs_rise_c, cs_fall_c;
  logic mosi_lvl, mosi_rise_c, mosi_fall_c;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d(sck),
    .q(sck_lvl), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_n),
    .q(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(mosi),
    .q(mosi_lvl), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );

  // Only the sck edges and the mosi level are consumed.
  logic unused_sync;
  assign unused_sync = &{1'b0, sck_lvl, mosi_rise_c, mosi_fall_c};

  jstk2_frame_t snap_c;
  assign snap_c = '{x: x_in, y: y_in, buttons: fs_buttons_in};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic                  miso_q, miso_d;
  logic [7:0]            rx_cmd_q, rx_cmd_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  busy_q, busy_d;
  logic [FLUSH_W-1:0]    flush_q, flush_d;
  logic                  armed_q, armed_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      miso_q   <= 1'b0;
      rx_cmd_q <= 8'h00;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      flush_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      miso_q   <= miso_d;
      rx_cmd_q <= rx_cmd_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      flush_q  <= flush_d;
      armed_q  <= armed_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    miso_d   = miso_q;
    rx_cmd_d = rx_cmd_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    busy_d   = busy_q;
    flush_d  = flush_q;
    armed_d  = armed_q;

    // After reset, let the synchronizers flush their reset values and then
    // require cs_n to be seen high, so a chip-select already low at release
    // cannot be mistaken for a fresh falling edge.
    if (flush_q != FLUSH_W'(FLUSH_MAX)) begin
      flush_d = flush_q + FLUSH_W'(1);
    end else if (cs_lvl) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        busy_d = 1'b0;
        // Load wins over any sck edge seen in the same cycle.
        if (armed_q && cs_fall_c) begin
          tx_d    = FRAME_BITS'(snap_c);
          rx_d    = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise_c) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sck_fall_c) begin
          miso_d  = tx_q[FRAME_BITS-1];
          tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
          count_d = count_q + CNT_W'(1);
          if (count_d == CNT_W'(FRAME_BITS)) begin
            state_d = ST_DONE;
          end
        end else if (sck_rise_c) begin
          rx_d = {rx_q[FRAME_BITS-2:0], mosi_lvl};
        end
      end

      ST_DONE: begin
        if (cs_rise_c) begin
          done_d   = 1'b1;
          rx_cmd_d = rx_q[FRAME_BITS-1 -: 8];
          busy_d   = 1'b0;
          miso_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (sck_fall_c) begin
          miso_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign miso        = miso_q;
  assign rx_cmd      = rx_cmd_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench for jstk2_spi_responder: a behavioural SPI master reads
// frames and the results are compared against hand-computed values.
module tb_jstk2_spi_responder;

  localparam int HALF = 80;  // half sck period = 8 clk cycles

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [7:0]  fs_buttons_in;
  logic [7:0]  rx_cmd;
  logic        frame_done;
  logic        frame_abort;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int both_cnt = 0;

  jstk2_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .x_in(x_in), .y_in(y_in), .fs_buttons_in(fs_buttons_in),
    .rx_cmd(rx_cmd), .frame_done(frame_done), .frame_abort(frame_abort),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done)                 done_cnt++;
    if (frame_abort)                abort_cnt++;
    if (frame_done && frame_abort)  both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Master: sck idles low; mosi changes on falling edges, miso is read just
  // before the next rising edge. rd is MSB-aligned at bit 47.
  task automatic spi_frame(input int nbits, input logic [47:0] mw,
                           input int chg_bit, input logic [15:0] chg_x,
                           input bit raise_cs,
                           output logic [47:0] rd, output logic busy_seen);
    rd = '0;
    cs_n = 1'b0;
    mosi = mw[47];
    #(HALF);
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_in = chg_x;
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
      if (i < 47) mosi = mw[46-i];
      #(HALF);
      rd[47-i] = miso;
    end
    if (raise_cs) begin
      cs_n = 1'b1;
      #(2*HALF);
    end
  endtask

  logic [47:0] rd;
  logic        bsy;
  int          d0, a0;

  initial begin
    reset_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    x_in = '0; y_in = '0; fs_buttons_in = '0;
    @(negedge clk);
    #50;
    check("rst_miso",  64'(miso),        64'h0);
    check("rst_rxcmd", 64'(rx_cmd),      64'h0);
    check("rst_done",  64'(frame_done),  64'h0);
    check("rst_abort", 64'(frame_abort), 64'h0);
    check("rst_busy",  64'(busy),        64'h0);
    reset_n = 1'b1;
    #100;

    // Extreme values with both buttons.
    x_in = 16'hFFFF; y_in = 16'h0000; fs_buttons_in = 8'h03;
    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(40, 48'h0, -1, 16'h0, 1'b1, rd, bsy);
    check("f1_busy_mid", 64'(bsy),           64'h1);
    check("f1_data",     64'(rd[47:8]),      64'hFF_FF00_0003);
    check("f1_done",     64'(done_cnt - d0), 64'h1);
    check("f1_abort",    64'(abort_cnt - a0), 64'h0);
    check("f1_busy_end", 64'(busy),          64'h0);
    check("f1_rxcmd",    64'(rx_cmd),        64'h00);

    // Mid-scale values and a command byte.
    x_in = 16'h8000; y_in = 16'h8000; fs_buttons_in = 8'h00;
    d0 = done_cnt;
    spi_frame(40, 48'hC0_0000_0000_00, -1, 16'h0, 1'b1, rd, bsy);
    check("f2_data",  64'(rd[47:8]),      64'h80_0080_0000);
    check("f2_rxcmd", 64'(rx_cmd),        64'hC0);
    check("f2_done",  64'(done_cnt - d0), 64'h1);

    // x_in changes mid-frame; the snapshot must hold.
    x_in = 16'h1234; y_in = 16'h5678; fs_buttons_in = 8'h5A;
    d0 = done_cnt;
    spi_frame(40, 48'h3C_FFFF_FFFF_00, 10, 16'hABCD, 1'b1, rd, bsy);
    check("f3_data",  64'(rd[47:8]),      64'h12_3456_785A);
    check("f3_rxcmd", 64'(rx_cmd),        64'h3C);
    check("f3_done",  64'(done_cnt - d0), 64'h1);

    // Abort after 17 bits: rx_cmd must keep 3C.
    x_in = 16'hA55A; y_in = 16'h0F0F; fs_buttons_in = 8'h01;
    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(17, 48'hFF_0000_0000_00, -1, 16'h0, 1'b1, rd, bsy);
    check("ab_bits",  64'(rd[47:31]),      64'h14AB4);
    check("ab_abort", 64'(abort_cnt - a0), 64'h1);
    check("ab_done",  64'(done_cnt - d0),  64'h0);
    check("ab_rxcmd", 64'(rx_cmd),         64'h3C);
    check("ab_busy",  64'(busy),           64'h0);

    // Next full frame after the abort.
    d0 = done_cnt;
    spi_frame(40, 48'hA5_0000_0000_00, -1, 16'h0, 1'b1, rd, bsy);
    check("f4_data",  64'(rd[47:8]),      64'hA5_5A0F_0F01);
    check("f4_rxcmd", 64'(rx_cmd),        64'hA5);
    check("f4_done",  64'(done_cnt - d0), 64'h1);

    // Reset in the middle of a frame, released with cs_n still low.
    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(20, 48'hFF_FFFF_FFFF_FF, -1, 16'h0, 1'b0, rd, bsy);
    check("rr_busy_pre", 64'(bsy), 64'h1);
    reset_n = 1'b0;
    #50;
    check("rr_busy_rst", 64'(busy),   64'h0);
    check("rr_rxcmd",    64'(rx_cmd), 64'h00);
    reset_n = 1'b1;
    #100;
    spi_frame(8, 48'hFF_FFFF_FFFF_FF, -1, 16'h0, 1'b1, rd, bsy);
    check("rr_busy_post", 64'(bsy),            64'h0);
    check("rr_miso",      64'(rd[47:40]),      64'h00);
    check("rr_no_done",   64'(done_cnt - d0),  64'h0);
    check("rr_no_abort",  64'(abort_cnt - a0), 64'h0);

    // 48-bit read: bits beyond the frame read zero.
    x_in = 16'hC3A5; y_in = 16'h5A3C; fs_buttons_in = 8'h81;
    d0 = done_cnt;
    spi_frame(48, 48'h77_0000_0000_00, -1, 16'h0, 1'b1, rd, bsy);
    check("f5_data",  64'(rd),            64'hC3A5_5A3C_8100);
    check("f5_rxcmd", 64'(rx_cmd),        64'h77);
    check("f5_done",  64'(done_cnt - d0), 64'h1);

    check("pulse_overlap", 64'(both_cnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
